// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit combinational ALU.
// Grants in IDLE, executes for one cycle, then holds the tagged response.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_result,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [IDW:0] N = (IDW+1)'(NREQ);

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_hit;
    logic [IDW:0]   pos;
    logic           accept;
    logic           illegal;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;
    logic [2:0]     sel_op;

    // search last+1 .. last+NREQ, wrapping once
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = {1'b0, last} + (IDW+1)'(k);
            if (pos >= N)
                pos = pos - N;
            if (!gnt_hit && req_valid[pos[IDW-1:0]]) begin
                gnt_hit = 1'b1;
                gnt_idx = pos[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_a  = req_a[8*i +: 8];
                sel_b  = req_b[8*i +: 8];
                sel_op = req_op[3*i +: 3];
            end
        end
    end

    assign accept  = (state == IDLE) && gnt_hit;
    assign illegal = alu_opcode > 3'd4;
    assign busy    = state != IDLE;

    always_comb begin
        req_ready = '0;
        if (accept && rst_n)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (gnt_hit) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= IDW'(NREQ-1);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                last       <= gnt_idx;
                rsp_id     <= gnt_idx;
                alu_a      <= sel_a;
                alu_b      <= sel_b;
                alu_opcode <= sel_op;
            end
            // illegal opcodes report zero data regardless of the ALU
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_err    <= illegal;
                rsp_result <= illegal ? 8'd0 : alu_result;
                rsp_carry  <= !illegal && alu_carry;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model of grant order, latency and response contents.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    logic        rsp_err;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    int         m_phase;
    int         m_last;
    int         m_acc = 0;
    int         m_id;
    int         hs = 0;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [2:0] m_op;
    logic [7:0] e_res;
    logic       e_car;
    logic       e_err;
    logic       seen_valid;
    int         glog[$];

    alu_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // external ALU; drives junk on illegal opcodes so zeroing is visible
    always_comb begin
        alu_result = 8'hA5;
        alu_carry  = 1'b1;
        case (alu_opcode)
            3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: begin alu_result = alu_a & alu_b; alu_carry = 1'b0; end
            3'd3: begin alu_result = alu_a | alu_b; alu_carry = 1'b0; end
            3'd4: begin alu_result = alu_a ^ alu_b; alu_carry = 1'b0; end
            default: ;
        endcase
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (last + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int g);
        return (g < 0) ? 4'b0 : 4'(1 << g);
    endfunction

    function automatic logic [9:0] ref_op(int a, int b, int op);
        int r;
        bit c;
        bit e;
        r = 0; c = 0; e = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); end
            1: begin r = a - b; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: e = 1;
        endcase
        if (r < 0) r += 256;
        r = r % 256;
        return {e, c, r[7:0]};
    endfunction

    task automatic set_req(int id, int a, int b, int op);
        req_a[8*id +: 8]  = 8'(a);
        req_b[8*id +: 8]  = 8'(b);
        req_op[3*id +: 3] = 3'(op);
    endtask

    // advance the model over the coming rising edge
    task automatic model_edge();
        int g;
        logic [9:0] e;
        if (seen_valid && rsp_ready) hs++;
        case (m_phase)
            0: begin
                g = rr(req_valid, m_last);
                if (g >= 0) begin
                    m_a  = 8'(req_a >> (8*g));
                    m_b  = 8'(req_b >> (8*g));
                    m_op = 3'(req_op >> (3*g));
                    e = ref_op(int'(m_a), int'(m_b), int'(m_op));
                    {e_err, e_car, e_res} = e;
                    m_id = g;
                    m_last = g;
                    m_phase = 1;
                    m_acc++;
                    glog.push_back(g);
                end
            end
            1: m_phase = 2;
            default: if (rsp_ready) m_phase = 0;
        endcase
    endtask

    task automatic cyc();
        if (rst_n) model_edge();
        @(negedge clk);
        #1;
        seen_valid = rsp_valid;
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("req_ready", 32'(req_ready),
            32'((m_phase == 0) ? onehot(rr(req_valid, m_last)) : 4'b0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_op", 32'(alu_opcode), 32'(m_op));
        if (m_phase == 2) begin
            chk("rsp_result", 32'(rsp_result), 32'(e_res));
            chk("rsp_carry", 32'(rsp_carry), 32'(e_car));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_err", 32'(rsp_err), 32'(e_err));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_phase = 0; m_last = 3; m_id = 0;
        m_a = 0; m_b = 0; m_op = 0;
        e_res = 0; e_car = 0; e_err = 0;
        seen_valid = 0;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 0);
        chk("rst_rsp", 32'({rsp_valid, rsp_result, rsp_carry, rsp_id, rsp_err}), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_op(int id, int a, int b, int op, int hold, logic [3:0] others);
        int n0;
        int h0;
        int k;
        n0 = m_acc;
        k = 0;
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        rsp_ready = (hold == 0);
        while (m_acc == n0 && k < 20) begin
            cyc();
            k++;
        end
        chk("accept", 32'(m_acc - n0), 1);
        req_valid[id] = 1'b0;
        req_valid = req_valid | others;
        cyc();
        repeat (hold) cyc();
        req_valid = req_valid & ~others;
        h0 = hs;
        rsp_ready = 1'b1;
        cyc();
        chk("handshake", 32'(hs - h0), 1);
    endtask

    initial begin
        int g0;
        int k;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        do_reset();

        set_req(0, 10, 5, 0);
        req_valid[0] = 1'b1;
        #1;
        chk("first_ready", 32'(req_ready), 1);
        do_op(0, 10, 5, 0, 0, 4'b0);
        do_op(2, 200, 100, 0, 0, 4'b0);
        do_op(1, 8'h55, 8'h0F, 5, 0, 4'b0);
        do_op(1, 10, 3, 1, 0, 4'b0);
        do_op(3, 8'h40, 8'h22, 4, 5, 4'b0011);

        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1, 2, 0);
        set_req(1, 9, 4, 1);
        set_req(2, 8'h0C, 8'h0A, 4);
        set_req(3, 8'h30, 8'h03, 3);
        req_valid = 4'hF;
        g0 = glog.size();
        k = 0;
        while (glog.size() < g0 + 6 && k < 40) begin
            cyc();
            k++;
            if (rsp_valid && rsp_id == 2'd2)
                chk("rr_xor", 32'(rsp_result), 32'h06);
        end
        req_valid = '0;
        chk("rr_count", 32'(glog.size() - g0), 6);
        for (int i = 0; i < glog.size() - g0; i++)
            chk("rr_order", 32'(glog[g0+i]), 32'(i % 4));
        repeat (3) cyc();

        set_req(2, 7, 7, 2);
        req_valid = 4'b0100;
        cyc();
        set_req(0, 3, 4, 0);
        req_valid = 4'hF;
        do_reset();
        g0 = glog.size();
        cyc();
        chk("rst_first", 32'(glog.size() - g0), 1);
        if (glog.size() > g0)
            chk("rst_first_id", 32'(glog[g0]), 0);
        req_valid = '0;
        repeat (3) cyc();

        for (int n = 0; n < 1500; n++) begin
            if (m_phase != 0 || req_valid == 0) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'($urandom_range(0, 1));
                        set_req(i, int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 255)),
                                int'($urandom_range(0, 7)));
                    end
                end
            end
            rsp_ready = $urandom_range(0, 3) != 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
